// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Two-requester arbiter in front of a single shared memory port.
// Requester 0 is the CPU, requester 1 is the loader/DMA engine.
//
// FSM: IDLE -> ACC -> (RESP on read) -> IDLE
//   IDLE : sample req0/req1, pick a winner, latch its access.
//   ACC  : the access is on the memory port for exactly one cycle;
//          gnt of the owner is high in this cycle.
//   RESP : mem_rdata is valid; rvalid of the owner is high.
//
// Handshake: req is a level. A request is accepted only when it is
// sampled in IDLE; req/we/addr/wdata must stay stable until gnt is
// seen, and req must drop in the cycle after gnt unless another access
// is wanted (a req still high in the next IDLE is a new request).
// gnt marks the cycle the access is issued; rvalid marks the single
// cycle read data is on rdata. Requests raised in ACC or RESP wait.
//
// Optional feature: define ARB_ROUND_ROBIN_EN to alternate between the
// requesters on simultaneous requests (the one that is not last_owner
// wins). Without it, requester 0 always wins a tie.
//
// dbg_state_o exposes the FSM state for observation.

module mem_port_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rvalid0,
  output logic        rvalid1,
  output logic [31:0] rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic [1:0]  dbg_state_o
);

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] ACC  = 2'b01;
  localparam logic [1:0] RESP = 2'b10;

  logic [1:0]  state_q, state_d;
  logic        owner_q, owner_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        mem_rd_q, mem_rd_d;
  logic        mem_wr_q, mem_wr_d;

  // Arbitration result for the current IDLE sample.
  logic        any_req;
  logic        start;
  logic        win_owner;
  logic        win_we;
  logic [31:0] win_addr;
  logic [31:0] win_wdata;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_owner_q, last_owner_d;

  // Tie goes to whoever did not win last time; a lone request always wins.
  always_comb begin
    if (req0 && req1) begin
      win_owner = ~last_owner_q;
    end else begin
      win_owner = req1;
    end
  end

  // last_owner follows every accepted access.
  always_comb begin
    last_owner_d = last_owner_q;
    if (start) begin
      last_owner_d = win_owner;
    end
  end

  // last_owner starts at 1 so the first tie after reset goes to requester 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_owner_q <= 1'b1;
    end else begin
      last_owner_q <= last_owner_d;
    end
  end
`else
  // Fixed priority: requester 1 wins only when requester 0 is silent.
  always_comb begin
    win_owner = ~req0;
  end
`endif

  // Mux the winning requester's access fields.
  always_comb begin
    any_req   = req0 | req1;
    start     = (state_q == IDLE) && any_req;
    win_we    = win_owner ? we1    : we0;
    win_addr  = win_owner ? addr1  : addr0;
    win_wdata = win_owner ? wdata1 : wdata0;
  end

  // Next-state logic for the IDLE/ACC/RESP sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = ACC;
        end
      end
      ACC: begin
        // mem_wr_q still holds the latched direction of this access.
        if (mem_wr_q) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Access latch: loaded only on IDLE->ACC so the port holds its last
  // address/data afterwards; strobes are high only for the ACC cycle.
  always_comb begin
    owner_d     = owner_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_rd_d    = 1'b0;
    mem_wr_d    = 1'b0;
    if (start) begin
      owner_d     = win_owner;
      mem_addr_d  = win_addr;
      mem_wdata_d = win_wdata;
      mem_rd_d    = ~win_we;
      mem_wr_d    = win_we;
    end
  end

  // FSM state and owner registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  // Registered memory port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
    end else begin
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
    end
  end

  // Status outputs decoded from registered state only.
  always_comb begin
    gnt0        = (state_q == ACC)  && !owner_q;
    gnt1        = (state_q == ACC)  &&  owner_q;
    rvalid0     = (state_q == RESP) && !owner_q;
    rvalid1     = (state_q == RESP) &&  owner_q;
    busy        = (state_q != IDLE);
    rdata       = mem_rdata;
    mem_addr    = mem_addr_q;
    mem_wdata   = mem_wdata_q;
    mem_rd      = mem_rd_q;
    mem_wr      = mem_wr_q;
    dbg_state_o = state_q;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: a table of per-cycle vectors with
// hand-computed outputs, followed by directed multi-cycle sequences
// (tie arbitration order, late request, reset mid-access) and a
// per-cycle mutual-exclusion monitor.

module tb_mem_port_arbiter;

  // ---------------- clock / reset ----------------
  logic        clk;
  logic        reset;
  logic        req0, req1, we0, we1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic        mem_rd, mem_wr, busy;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .req0       (req0),
    .req1       (req1),
    .we0        (we0),
    .we1        (we1),
    .addr0      (addr0),
    .addr1      (addr1),
    .wdata0     (wdata0),
    .wdata1     (wdata1),
    .gnt0       (gnt0),
    .gnt1       (gnt1),
    .rvalid0    (rvalid0),
    .rvalid1    (rvalid1),
    .rdata      (rdata),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .mem_rdata  (mem_rdata),
    .busy       (busy),
    .dbg_state_o(dbg_state)
  );

  // ---------------- vector table type ----------------
  typedef struct {
    string       name;
    logic        r0, w0;
    logic [31:0] a0, d0;
    logic        r1, w1;
    logic [31:0] a1, d1;
    logic [31:0] mrd;
    logic [1:0]  g;    // {gnt1, gnt0}
    logic [1:0]  rv;   // {rvalid1, rvalid0}
    logic        rd, wr, bsy;
    logic [31:0] ma, mw;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(string nm,
                              logic r0, logic w0, logic [31:0] a0, logic [31:0] d0,
                              logic r1, logic w1, logic [31:0] a1, logic [31:0] d1,
                              logic [31:0] mrd, logic [1:0] g, logic [1:0] rv,
                              logic rd, logic wr, logic bsy,
                              logic [31:0] ma, logic [31:0] mw);
    vec_t v;
    v.name = nm;
    v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.mrd = mrd; v.g = g; v.rv = rv;
    v.rd = rd; v.wr = wr; v.bsy = bsy; v.ma = ma; v.mw = mw;
    return v;
  endfunction

  // ---------------- driver / checker tasks ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    req0 = 1'b0; we0 = 1'b0; addr0 = 32'h0; wdata0 = 32'h0;
    req1 = 1'b0; we1 = 1'b0; addr1 = 32'h0; wdata1 = 32'h0;
    mem_rdata = 32'h0;
  endtask

  // Advance one cycle; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic apply_vec(input vec_t v);
    req0 = v.r0; we0 = v.w0; addr0 = v.a0; wdata0 = v.d0;
    req1 = v.r1; we1 = v.w1; addr1 = v.a1; wdata1 = v.d1;
    mem_rdata = v.mrd;
    step();
    chk({v.name, ".gnt"},       {30'h0, gnt1, gnt0},       {30'h0, v.g});
    chk({v.name, ".rvalid"},    {30'h0, rvalid1, rvalid0}, {30'h0, v.rv});
    chk({v.name, ".mem_rd"},    {31'h0, mem_rd},           {31'h0, v.rd});
    chk({v.name, ".mem_wr"},    {31'h0, mem_wr},           {31'h0, v.wr});
    chk({v.name, ".busy"},      {31'h0, busy},             {31'h0, v.bsy});
    chk({v.name, ".mem_addr"},  mem_addr,                  v.ma);
    chk({v.name, ".mem_wdata"}, mem_wdata,                 v.mw);
    if (v.rv != 2'b00) chk({v.name, ".rdata"}, rdata, v.mrd);
  endtask

  // ---------------- invariant monitor ----------------
  always @(negedge clk) begin
    checks++;
    if ((gnt0 && gnt1) || (rvalid0 && rvalid1) || (mem_rd && mem_wr)) begin
      errors++;
      $display("FAIL exclusion: got gnt=%b%b rvalid=%b%b rd/wr=%b%b required no pair both 1",
               gnt1, gnt0, rvalid1, rvalid0, mem_rd, mem_wr);
    end
  end

  // ---------------- scoreboard for tie arbitration ----------------
  logic [0:0] exp_q[$];

  // ---------------- main test ----------------
  initial begin
    logic [0:0] exp_owner;
    int         grants;

    idle_inputs();
    reset = 1'b1;

    // Vector table: one row per cycle starting from a fresh IDLE.
    //         name   r0 w0 a0     d0           r1 w1 a1     d1           mrd          g      rv     rd wr bsy ma     mw
    vt.push_back(mk("rd0_acc",  1,0,32'h10,32'h0,        0,0,32'h0, 32'h0,        32'h0,       2'b01,2'b00,1,0,1,32'h10,32'h0));
    vt.push_back(mk("rd0_resp", 0,0,32'h0, 32'h0,        0,0,32'h0, 32'h0,        32'hDEADBEEF,2'b00,2'b01,0,0,1,32'h10,32'h0));
    vt.push_back(mk("rd0_idle", 0,0,32'h0, 32'h0,        0,0,32'h0, 32'h0,        32'h0,       2'b00,2'b00,0,0,0,32'h10,32'h0));
    vt.push_back(mk("wr1_acc",  0,0,32'h0, 32'h0,        1,1,32'h20,32'h12345678, 32'h0,       2'b10,2'b00,0,1,1,32'h20,32'h12345678));
    vt.push_back(mk("wr1_idle", 0,0,32'h0, 32'h0,        0,0,32'h0, 32'h0,        32'h0,       2'b00,2'b00,0,0,0,32'h20,32'h12345678));
    vt.push_back(mk("wr0_acc",  1,1,32'h30,32'hA5A5A5A5, 0,0,32'h0, 32'h0,        32'h0,       2'b01,2'b00,0,1,1,32'h30,32'hA5A5A5A5));
    vt.push_back(mk("late1_wt", 0,0,32'h0, 32'h0,        1,0,32'h40,32'h0,        32'h0,       2'b00,2'b00,0,0,0,32'h30,32'hA5A5A5A5));
    vt.push_back(mk("rd1_acc",  0,0,32'h0, 32'h0,        1,0,32'h40,32'h0,        32'h0,       2'b10,2'b00,1,0,1,32'h40,32'h0));
    vt.push_back(mk("rd1_resp", 0,0,32'h0, 32'h0,        0,0,32'h0, 32'h0,        32'hCAFEF00D,2'b00,2'b10,0,0,1,32'h40,32'h0));
    vt.push_back(mk("rd1_idle", 0,0,32'h0, 32'h0,        0,0,32'h0, 32'h0,        32'h0,       2'b00,2'b00,0,0,0,32'h40,32'h0));
    vt.push_back(mk("tie_acc",  1,0,32'h50,32'h77,       1,1,32'h60,32'h11,       32'h0,       2'b01,2'b00,1,0,1,32'h50,32'h77));
    vt.push_back(mk("tie_resp", 0,0,32'h0, 32'h0,        1,1,32'h60,32'h11,       32'h55,      2'b00,2'b01,0,0,1,32'h50,32'h77));
    vt.push_back(mk("tie_idle", 0,0,32'h0, 32'h0,        1,1,32'h60,32'h11,       32'h0,       2'b00,2'b00,0,0,0,32'h50,32'h77));
    vt.push_back(mk("tie_wr1",  0,0,32'h0, 32'h0,        1,1,32'h60,32'h11,       32'h0,       2'b10,2'b00,0,1,1,32'h60,32'h11));
    vt.push_back(mk("tie_done", 0,0,32'h0, 32'h0,        0,0,32'h0, 32'h0,        32'h0,       2'b00,2'b00,0,0,0,32'h60,32'h11));

    // Reset state, sampled while reset is still asserted.
    step();
    chk("rst.gnt",       {30'h0, gnt1, gnt0},       32'h0);
    chk("rst.rvalid",    {30'h0, rvalid1, rvalid0}, 32'h0);
    chk("rst.mem_rd_wr", {30'h0, mem_rd, mem_wr},   32'h0);
    chk("rst.mem_addr",  mem_addr,                  32'h0);
    chk("rst.mem_wdata", mem_wdata,                 32'h0);
    chk("rst.busy",      {31'h0, busy},             32'h0);
    step();
    reset = 1'b0;

    for (int i = 0; i < vt.size(); i++) begin
      apply_vec(vt[i]);
    end
    idle_inputs();

    // Tie arbitration order from a fresh reset, both requesters reading.
    do_reset();
`ifdef ARB_ROUND_ROBIN_EN
    exp_q.push_back(1'b0); exp_q.push_back(1'b1);
    exp_q.push_back(1'b0); exp_q.push_back(1'b1);
`else
    exp_q.push_back(1'b0); exp_q.push_back(1'b0);
    exp_q.push_back(1'b0); exp_q.push_back(1'b0);
`endif
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h100;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h200;
    grants = 0;
    for (int cyc = 0; cyc < 30 && grants < 4; cyc++) begin
      step();
      if (gnt0 || gnt1) begin
        exp_owner = exp_q.pop_front();
        chk("tie.owner", {31'h0, gnt1}, {31'h0, exp_owner});
        chk("tie.addr",  mem_addr, exp_owner ? 32'h200 : 32'h100);
        grants++;
      end
    end
    checks++;
    if (grants != 4) begin
      errors++;
      $display("FAIL tie.count: got %0d grants expected 4 within 30 cycles", grants);
    end
    idle_inputs();
    step(); step(); step();

    // Late request: req1 rises during RESP of a requester-0 read.
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h70;
    step();
    chk("late.gnt0", {31'h0, gnt0}, 32'h1);
    req0 = 1'b0;
    step();
    chk("late.rvalid0", {31'h0, rvalid0}, 32'h1);
    chk("late.gnt1_resp", {31'h0, gnt1}, 32'h0);
    req1 = 1'b1; we1 = 1'b1; addr1 = 32'h80; wdata1 = 32'h99;
    step();
    chk("late.gnt1_idle", {31'h0, gnt1}, 32'h0);
    chk("late.busy_idle", {31'h0, busy}, 32'h0);
    step();
    chk("late.gnt1", {31'h0, gnt1}, 32'h1);
    chk("late.mem_wr", {31'h0, mem_wr}, 32'h1);
    chk("late.addr", mem_addr, 32'h80);
    req1 = 1'b0;
    step();
    chk("late.done", {31'h0, busy}, 32'h0);

    // Reset pulsed in the ACC cycle of a read.
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h90;
    step();
    chk("rstacc.mem_rd_before", {31'h0, mem_rd}, 32'h1);
    #2;
    reset = 1'b1;
    req0 = 1'b0;
    #1;
    chk("rstacc.mem_rd", {31'h0, mem_rd}, 32'h0);
    chk("rstacc.gnt0",   {31'h0, gnt0},   32'h0);
    chk("rstacc.busy",   {31'h0, busy},   32'h0);
    chk("rstacc.addr",   mem_addr,        32'h0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("rstacc.no_rvalid", {30'h0, rvalid1, rvalid0}, 32'h0);
      chk("rstacc.no_gnt",    {30'h0, gnt1, gnt0},       32'h0);
      chk("rstacc.idle",      {31'h0, busy},             32'h0);
    end

    // ---------------- final report ----------------
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
